// File: rtl/sine_dds.sv
// sine_dds - direct-digital-synthesis sine source with a valid/ready output.
//
// A phase accumulator advances by a runtime tuning word for every issued
// sample. Each phase is folded onto a quarter-wave magnitude table, the
// magnitude is scaled by an unsigned amplitude and the sign is restored.
// The result is delivered on a stream with valid/ready handshaking.
//
// Pipeline: S1 (fold) -> S2 (table read) -> OUT (scale + sign). The three
// stages stall together whenever out holds a sample the sink has not taken.
//
// The quarter-wave table (N+1 entries over 0..pi/2 inclusive, entry N at
// full scale) is generated at elaboration, so no external init file is needed.
//
// Optional build macro SINE_DDS_QUAD_OUT_EN adds the cosine channel out_q.
// It uses its own fold/table read path on phase + pi/2 and shares the
// amplitude, handshake and latency of out.
//
// Ports:
//   clk        clock
//   reset      synchronous active-low reset
//   enable     1 = issue new samples into the pipeline
//   ftw        frequency tuning word, the phase increment per sample
//   amp        unsigned amplitude; values above unity saturate to unity
//   phase_clr  pulse that clears the phase accumulator
//   ready      downstream accepts the sample on out
//   valid      out holds a sample
//   out        signed sine sample
//   out_q      signed cosine sample (SINE_DDS_QUAD_OUT_EN only)

module sine_dds #(
    parameter int DATA_W  = 24,
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8,
    parameter int AMP_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PHASE_W-1:0] ftw,
    input  logic [AMP_W-1:0]   amp,
    input  logic               phase_clr,
    input  logic               ready,
    output logic               valid,
`ifdef SINE_DDS_QUAD_OUT_EN
    output logic [DATA_W-1:0]  out_q,
`endif
    output logic [DATA_W-1:0]  out
);

    localparam int N      = 1 << LUT_AW;
    localparam int MAG_W  = DATA_W - 1;
    localparam int PROD_W = MAG_W + AMP_W;
    localparam logic [AMP_W-1:0] AMP_UNITY = {1'b1, {(AMP_W-1){1'b0}}};
    localparam logic [LUT_AW:0]  ADDR_N    = {1'b1, {LUT_AW{1'b0}}};

    // Table entry for angle (pi/2)*idx/N, rounded to nearest, full scale
    // 2^(DATA_W-1)-1. Evaluated only with constant arguments.
    function automatic logic [MAG_W-1:0] sin_mag(input int idx);
        real x;
        real term;
        real sum;
        real full;
        real v;
        x    = 1.5707963267948966 * real'(idx) / real'(N);
        term = x;
        sum  = x;
        for (int k = 1; k < 20; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        full = (2.0 ** MAG_W) - 1.0;
        v    = sum * full + 0.5;
        if (v > full) v = full;
        if (v < 0.0)  v = 0.0;
        return MAG_W'($rtoi(v));
    endfunction

    // Quarter-wave fold: returns {negate, table address}. The quadrant and
    // table index are the top LUT_AW+2 phase bits; odd quadrants mirror the
    // index so the table runs backwards from the peak.
    function automatic logic [LUT_AW+1:0] fold(input logic [PHASE_W-1:0] p);
        logic [LUT_AW+1:0] top;
        logic [LUT_AW:0]   idx;
        logic [LUT_AW:0]   addr;
        top  = (LUT_AW+2)'(p >> (PHASE_W - LUT_AW - 2));
        idx  = {1'b0, top[LUT_AW-1:0]};
        addr = top[LUT_AW] ? (ADDR_N - idx) : idx;
        return {top[LUT_AW+1], addr};
    endfunction

    // Amplitude scaling with truncation toward zero on the magnitude, then
    // sign restore. Magnitude never exceeds 2^(DATA_W-1)-1, so the negation
    // can never produce the most negative code.
    function automatic logic [DATA_W-1:0] scale(
        input logic [MAG_W-1:0] mag,
        input logic             neg,
        input logic [AMP_W-1:0] a
    );
        logic [AMP_W-1:0]  a_sat;
        logic [PROD_W-1:0] prod;
        logic [DATA_W-1:0] m;
        a_sat = (a > AMP_UNITY) ? AMP_UNITY : a;
        prod  = PROD_W'(mag) * PROD_W'(a_sat);
        m     = DATA_W'(prod >> (AMP_W - 1));
        return neg ? -m : m;
    endfunction

    // Quarter-wave magnitude ROM, read through a register in S2.
    logic [MAG_W-1:0] lut [0:N];

    generate
        for (genvar gi = 0; gi <= N; gi++) begin : g_lut
            assign lut[gi] = sin_mag(gi);
        end
    endgenerate

    logic [PHASE_W-1:0] phase_reg;
    logic               s1_valid_reg;
    logic [LUT_AW:0]    s1_addr_reg;
    logic               s1_neg_reg;
    logic               s2_valid_reg;
    logic [MAG_W-1:0]   s2_mag_reg;
    logic               s2_neg_reg;

    logic              adv;
    logic              issue;
    logic [LUT_AW+1:0] fold_i;

    // The whole pipeline moves only when out is empty or being taken.
    assign adv    = !valid || ready;
    assign issue  = enable && adv;
    assign fold_i = fold(phase_reg);

`ifdef SINE_DDS_QUAD_OUT_EN
    localparam logic [PHASE_W-1:0] QUARTER = {2'b01, {(PHASE_W-2){1'b0}}};

    logic [LUT_AW+1:0] fold_q;
    logic [LUT_AW:0]   s1_addr_q_reg;
    logic              s1_neg_q_reg;
    logic [MAG_W-1:0]  s2_mag_q_reg;
    logic              s2_neg_q_reg;

    assign fold_q = fold(phase_reg + QUARTER);

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_addr_q_reg <= '0;
            s1_neg_q_reg  <= 1'b0;
            s2_mag_q_reg  <= '0;
            s2_neg_q_reg  <= 1'b0;
            out_q         <= '0;
        end else if (adv) begin
            s1_addr_q_reg <= fold_q[LUT_AW:0];
            s1_neg_q_reg  <= fold_q[LUT_AW+1];
            s2_mag_q_reg  <= lut[s1_addr_q_reg];
            s2_neg_q_reg  <= s1_neg_q_reg;
            out_q         <= scale(s2_mag_q_reg, s2_neg_q_reg, amp);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_reg    <= '0;
            s1_valid_reg <= 1'b0;
            s1_addr_reg  <= '0;
            s1_neg_reg   <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_mag_reg   <= '0;
            s2_neg_reg   <= 1'b0;
            valid        <= 1'b0;
            out          <= '0;
        end else begin
            // A clear wins over the increment; a same-cycle issue still
            // captured the old phase through fold_i below.
            if (phase_clr) begin
                phase_reg <= '0;
            end else if (issue) begin
                phase_reg <= phase_reg + ftw;
            end

            if (adv) begin
                s1_valid_reg <= enable;
                s1_addr_reg  <= fold_i[LUT_AW:0];
                s1_neg_reg   <= fold_i[LUT_AW+1];
                s2_valid_reg <= s1_valid_reg;
                s2_mag_reg   <= lut[s1_addr_reg];
                s2_neg_reg   <= s1_neg_reg;
                valid        <= s2_valid_reg;
                // amp is taken here, as the sample enters OUT.
                out          <= scale(s2_mag_reg, s2_neg_reg, amp);
            end
        end
    end

endmodule

// File: tb/tb_sine_dds.sv
// tb_sine_dds - self-checking bench for sine_dds.
// The reference computes each accepted sample from its phase index with
// plain integer arithmetic over a sine table built with $sin, and checks the
// accepted stream in order. Build with SINE_DDS_QUAD_OUT_EN to also check out_q.

module tb_sine_dds;

    localparam int DW  = 24;
    localparam int PW  = 32;
    localparam int AMW = 16;
    localparam int N   = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [PW-1:0] ftw = '0;
    logic [AMW-1:0] amp = '0;
    logic          phase_clr = 1'b0;
    logic          ready = 1'b1;
    logic          valid;
    logic [DW-1:0] out;
`ifdef SINE_DDS_QUAD_OUT_EN
    logic [DW-1:0] out_q;
`endif

    always #5 clk = ~clk;

    sine_dds dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .ftw       (ftw),
        .amp       (amp),
        .phase_clr (phase_clr),
        .ready     (ready),
        .valid     (valid),
`ifdef SINE_DDS_QUAD_OUT_EN
        .out_q     (out_q),
`endif
        .out       (out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference quarter-wave magnitudes.
    longint tbl [0:N];

    // Sample value for phase p at amplitude a.
    function automatic logic [DW-1:0] model(input logic [PW-1:0] p, input int unsigned a);
        longint pl;
        longint quadrant;
        longint pos;
        longint idx;
        longint a_eff;
        longint m;
        longint v;
        pl       = longint'(p);
        quadrant = pl / (longint'(1) << 30);
        pos      = (pl % (longint'(1) << 30)) / (longint'(1) << 22);
        idx      = (quadrant % 2 == 1) ? (N - pos) : pos;
        a_eff    = (a > 32768) ? 32768 : longint'(a);
        m        = tbl[idx] * a_eff / 32768;
        v        = (quadrant >= 2) ? -m : m;
        return DW'(v);
    endfunction

    // Accepted-sample scoreboard, filled by the monitor.
    logic [DW-1:0] got_i [$];
    logic [DW-1:0] got_q [$];

    logic          prev_stall = 1'b0;
    logic          prev_rst = 1'b0;
    logic [DW-1:0] prev_out = '0;

    // Inputs only change just after posedge, so values seen at negedge are
    // the ones the next posedge samples.
    always @(negedge clk) begin
        if (prev_stall && prev_rst) begin
            check("stall_valid", valid, 1);
            check("stall_out", out, prev_out);
        end
        if (valid && ready && reset) begin
            got_i.push_back(out);
`ifdef SINE_DDS_QUAD_OUT_EN
            got_q.push_back(out_q);
            $display("acc %0d out=%h out_q=%h", got_i.size() - 1, out, out_q);
`else
            $display("acc %0d out=%h", got_i.size() - 1, out);
`endif
        end
        prev_stall <= valid && !ready;
        prev_out   <= out;
        prev_rst   <= reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        enable    = 1'b0;
        phase_clr = 1'b0;
        ready     = 1'b1;
        tick();
        tick();
        check("rst_valid", valid, 0);
        check("rst_out", out, 0);
`ifdef SINE_DDS_QUAD_OUT_EN
        check("rst_out_q", out_q, 0);
`endif
        reset = 1'b1;
        got_i.delete();
        got_q.delete();
    endtask

    // Run until m samples are accepted, optionally with random backpressure
    // that includes 5-cycle low runs.
    task automatic collect(input int m, input bit rand_ready, input string tag);
        int budget;
        int low_run;
        budget  = 4000;
        low_run = 0;
        while (got_i.size() < m && budget > 0) begin
            if (rand_ready) begin
                if (low_run > 0) begin
                    ready   = 1'b0;
                    low_run = low_run - 1;
                end else if ($urandom_range(0, 9) == 0) begin
                    ready   = 1'b0;
                    low_run = 4;
                end else begin
                    ready = 1'($urandom_range(0, 1));
                end
            end else begin
                ready = 1'b1;
            end
            tick();
            budget--;
        end
        ready = 1'b1;
        check({tag, "_count"}, got_i.size() >= m, 1);
    endtask

    // Compare accepted samples first..m-1 against phases base + (k-first)*f.
    task automatic cmp_stream(input string tag, input int first, input int m,
                              input logic [PW-1:0] f, input int unsigned a,
                              input logic [PW-1:0] base);
        logic [PW-1:0] p;
        for (int k = first; k < m && k < got_i.size(); k++) begin
            p = base + PW'(k - first) * f;
            check($sformatf("%s[%0d]", tag, k), got_i[k], model(p, a));
`ifdef SINE_DDS_QUAD_OUT_EN
            check($sformatf("%s_q[%0d]", tag, k), got_q[k], model(p + 32'h4000_0000, a));
`endif
        end
    endtask

    initial begin
        logic [DW-1:0] lit_i [4];
        logic [DW-1:0] lit_q [4];
        int unsigned   amps [3];
        logic [PW-1:0] rf;
        int unsigned   ra;

        for (int a = 0; a <= N; a++) begin
            tbl[a] = longint'($rtoi($sin(3.14159265358979323846 / 2.0 * a / N)
                                    * (2.0 ** 23 - 1.0) + 0.5));
        end
        lit_i = '{24'h000000, 24'h7FFFFF, 24'h000000, 24'h800001};
        lit_q = '{24'h7FFFFF, 24'h000000, 24'h800001, 24'h000000};

        // Reset state and first-sample latency.
        do_reset();
        ftw    = 32'h4000_0000;
        amp    = 16'h8000;
        enable = 1'b1;
        tick();
        check("lat_e1", valid, 0);
        tick();
        check("lat_e2", valid, 0);
        tick();
        check("lat_e3", valid, 1);
        check("lat_out", out, 0);
        collect(8, 0, "first");
        for (int k = 0; k < 8 && k < got_i.size(); k++) begin
            check($sformatf("first_lit[%0d]", k), got_i[k], lit_i[k % 4]);
`ifdef SINE_DDS_QUAD_OUT_EN
            check($sformatf("first_lit_q[%0d]", k), got_q[k], lit_q[k % 4]);
`endif
        end
        cmp_stream("first", 0, 8, ftw, 32'h8000, '0);

        // Amplitude scaling and saturation.
        amps = '{32'h4000, 32'h0000, 32'hFFFF};
        for (int j = 0; j < 3; j++) begin
            do_reset();
            ftw    = 32'h4000_0000;
            amp    = AMW'(amps[j]);
            enable = 1'b1;
            collect(8, 0, "amp");
            cmp_stream($sformatf("amp%h", amps[j]), 0, 8, ftw, amps[j], '0);
            if (got_i.size() >= 4) begin
                case (j)
                    0: begin
                        check("amp_half_peak", got_i[1], 24'h3FFFFF);
                        check("amp_half_trough", got_i[3], 24'hC00001);
                    end
                    1: check("amp_zero", got_i[1], 24'h000000);
                    default: begin
                        check("amp_sat_peak", got_i[1], 24'h7FFFFF);
                        check("amp_sat_trough", got_i[3], 24'h800001);
                    end
                endcase
            end
        end

        // Backpressure: fixed quarter-step run, then random tuning words.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            rf     = (r == 0) ? 32'h4000_0000 : PW'($urandom);
            ra     = (r == 0) ? 32'h8000 : $urandom_range(0, 32'hFFFF);
            ftw    = rf;
            amp    = AMW'(ra);
            enable = 1'b1;
            collect(50, 1, "bp");
            cmp_stream($sformatf("bp%0d", r), 0, 50, rf, ra, '0);
        end

        // Tuning word change with ftw=0 holds the current phase.
        do_reset();
        ftw    = 32'h4000_0000;
        amp    = 16'h8000;
        enable = 1'b1;
        tick();
        ftw    = '0;
        collect(6, 0, "ftw0");
        cmp_stream("ftw0_a", 0, 1, 32'h4000_0000, 32'h8000, '0);
        cmp_stream("ftw0_b", 1, 6, '0, 32'h8000, 32'h4000_0000);

        // Phase clear together with a new tuning word.
        do_reset();
        ftw    = 32'h4000_0000;
        amp    = 16'h8000;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                phase_clr = 1'b1;
                ftw       = 32'h2000_0000;
            end
            tick();
        end
        phase_clr = 1'b0;
        collect(16, 0, "clr");
        cmp_stream("clr_old", 0, 10, 32'h4000_0000, 32'h8000, '0);
        cmp_stream("clr_new", 10, 16, 32'h2000_0000, 32'h8000, '0);
        if (got_i.size() >= 13) begin
            check("clr_first", got_i[10], 24'h000000);
            check("clr_pi4", got_i[11], DW'(tbl[128]));
            check("clr_peak", got_i[12], 24'h7FFFFF);
        end

        // Enable drop, drain and re-enable.
        do_reset();
        ftw    = 32'h0123_4567;
        amp    = 16'h8000;
        enable = 1'b1;
        repeat (12) tick();
        enable = 1'b0;
        tick();
        tick();
        check("drain_v2", valid, 1);
        tick();
        check("drain_v3", valid, 0);
        repeat (7) tick();
        check("drain_idle", valid, 0);
        check("drain_cnt", got_i.size(), 12);
        enable = 1'b1;
        collect(30, 1, "reen");
        cmp_stream("reen", 0, 30, 32'h0123_4567, 32'h8000, '0);

        // Reset while stalled.
        do_reset();
        ftw    = 32'h4000_0000;
        amp    = 16'h8000;
        enable = 1'b1;
        repeat (6) tick();
        ready = 1'b0;
        tick();
        tick();
        check("mrst_pre_valid", valid, 1);
        reset  = 1'b0;
        enable = 1'b0;
        tick();
        check("mrst_valid", valid, 0);
        check("mrst_out", out, 0);
        reset = 1'b1;
        got_i.delete();
        got_q.delete();
        ready  = 1'b1;
        enable = 1'b1;
        collect(8, 0, "mrst");
        cmp_stream("mrst", 0, 8, 32'h4000_0000, 32'h8000, '0);
        if (got_i.size() >= 2) begin
            check("mrst_peak", got_i[1], 24'h7FFFFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
